// File: rtl/secuenciador_dosificacion_pkg.sv
// Shared encodings and helpers for the R/G/B dosing sequencer.
// Channel index and canal_activo share the same code (1=R, 2=G, 3=B).
package secuenciador_dosificacion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSA = 2'd2
  } estado_t;

  localparam logic [1:0] CANAL_NINGUNO = 2'd0;
  localparam logic [1:0] CANAL_R       = 2'd1;
  localparam logic [1:0] CANAL_G       = 2'd2;
  localparam logic [1:0] CANAL_B       = 2'd3;

  localparam int VALOR_MAX        = 15;
  localparam int VALOR_NO_CARGADO = 16;
  localparam int ANCHO_DOSIS      = $clog2(VALOR_MAX + 1);

  // Element 0 is R, 1 is G, 2 is B.
  typedef logic [2:0][ANCHO_DOSIS-1:0] dosis_t;

  // First channel after 'desde' whose dose is non-zero; zero doses are skipped.
  function automatic logic [1:0] siguiente_canal(input dosis_t d, input logic [1:0] desde);
    logic [1:0] res;
    res = CANAL_NINGUNO;
    for (int c = 3; c >= 1; c--)
      if (2'(c) > desde && d[c-1] != '0) res = 2'(c);
    return res;
  endfunction

  function automatic logic [ANCHO_DOSIS-1:0] dosis_de(input dosis_t d, input logic [1:0] canal);
    logic [ANCHO_DOSIS-1:0] res;
    case (canal)
      CANAL_R: res = d[0];
      CANAL_G: res = d[1];
      CANAL_B: res = d[2];
      default: res = '0;
    endcase
    return res;
  endfunction

  // Motor vector ordering is {B, G, R}.
  function automatic logic [2:0] motor_de(input logic [1:0] canal);
    logic [2:0] res;
    case (canal)
      CANAL_R: res = 3'b001;
      CANAL_G: res = 3'b010;
      CANAL_B: res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/secuenciador_dosificacion_contador.sv
// Loadable down-counter with zero flag; used for both run and pause timing.
// Load wins over enable; the count holds at zero.
module contador_descendente #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_carga,
  input  logic [ANCHO-1:0] i_valor,
  input  logic             i_en,
  output logic             o_cero
);

  logic [ANCHO-1:0] r_cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cuenta <= '0;
    else if (i_carga)                 r_cuenta <= i_valor;
    else if (i_en && r_cuenta != '0)  r_cuenta <= r_cuenta - 1'b1;
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/secuenciador_dosificacion.sv
// Runs the R, G, B dosing motors one at a time for dose x CICLOS_POR_UNIDAD
// cycles each, separated by an all-off pause; all outputs are registered.
module secuenciador_dosificacion
  import secuenciador_dosificacion_pkg::*;
#(
  parameter int CICLOS_POR_UNIDAD = 33_333,
  parameter int CICLOS_PAUSA      = 1_000,
  parameter int ANCHO_CONT        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic       abort,
  input  logic [4:0] R,
  input  logic [4:0] G,
  input  logic [4:0] B,
  output logic       motor_R,
  output logic       motor_G,
  output logic       motor_B,
  output logic [1:0] canal_activo,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [ANCHO_CONT-1:0] C_UNIDAD   = ANCHO_CONT'(CICLOS_POR_UNIDAD);
  localparam logic [ANCHO_CONT-1:0] C_PAUSA_M1 = ANCHO_CONT'(CICLOS_PAUSA - 1);
  localparam logic [ANCHO_CONT-1:0] C_UNO      = ANCHO_CONT'(1);

  estado_t    r_estado, w_sig_estado;
  logic [1:0] r_canal, w_sig_canal;
  dosis_t     r_dosis, w_sig_dosis;
  logic [2:0] r_motor, w_sig_motor;
  logic [1:0] r_canal_act, w_sig_canal_act;
  logic       r_busy, w_sig_busy;
  logic       r_done, w_sig_done;
  logic       r_error, w_sig_error;

  dosis_t                 w_dosis_in;
  logic                   w_invalida;
  logic [1:0]             w_primer, w_siguiente;
  logic [ANCHO_DOSIS-1:0] w_dosis_carga;
  logic [ANCHO_CONT-1:0]  w_dur_m1;
  logic                   w_carga, w_en, w_cero;
  logic [ANCHO_CONT-1:0]  w_valor;

  assign w_dosis_in  = {B[ANCHO_DOSIS-1:0], G[ANCHO_DOSIS-1:0], R[ANCHO_DOSIS-1:0]};
  assign w_invalida  = (R >= 5'(VALOR_NO_CARGADO)) || (G >= 5'(VALOR_NO_CARGADO)) ||
                       (B >= 5'(VALOR_NO_CARGADO));
  assign w_primer    = siguiente_canal(w_dosis_in, CANAL_NINGUNO);
  assign w_siguiente = siguiente_canal(r_dosis, r_canal);

  // In IDLE the run length comes straight from the inputs being latched this edge.
  assign w_dosis_carga = (r_estado == IDLE) ? dosis_de(w_dosis_in, w_primer)
                                            : dosis_de(r_dosis, r_canal);
  assign w_dur_m1 = {{(ANCHO_CONT-ANCHO_DOSIS){1'b0}}, w_dosis_carga} * C_UNIDAD - C_UNO;

  contador_descendente #(.ANCHO(ANCHO_CONT)) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_carga (w_carga),
    .i_valor (w_valor),
    .i_en    (w_en),
    .o_cero  (w_cero)
  );

  always_comb begin
    w_sig_estado    = r_estado;
    w_sig_canal     = r_canal;
    w_sig_dosis     = r_dosis;
    w_sig_motor     = 3'b000;
    w_sig_canal_act = CANAL_NINGUNO;
    w_sig_busy      = r_busy;
    w_sig_done      = 1'b0;
    w_sig_error     = 1'b0;
    w_carga         = 1'b0;
    w_en            = 1'b0;
    w_valor         = w_dur_m1;
    case (r_estado)
      IDLE: begin
        if (enter && !abort) begin
          if (w_invalida) begin
            w_sig_error = 1'b1;
          end else begin
            w_sig_dosis = w_dosis_in;
            if (w_primer == CANAL_NINGUNO) begin
              w_sig_done = 1'b1;
            end else begin
              w_sig_estado    = RUN;
              w_sig_canal     = w_primer;
              w_sig_busy      = 1'b1;
              w_carga         = 1'b1;
              w_sig_motor     = motor_de(w_primer);
              w_sig_canal_act = w_primer;
            end
          end
        end
      end
      RUN: begin
        if (abort) begin
          w_sig_estado = IDLE;
          w_sig_canal  = CANAL_NINGUNO;
          w_sig_busy   = 1'b0;
        end else if (w_cero) begin
          if (w_siguiente != CANAL_NINGUNO) begin
            // r_canal already points at the next run while pausing.
            w_sig_estado = PAUSA;
            w_sig_canal  = w_siguiente;
            w_carga      = 1'b1;
            w_valor      = C_PAUSA_M1;
          end else begin
            w_sig_estado = IDLE;
            w_sig_canal  = CANAL_NINGUNO;
            w_sig_busy   = 1'b0;
            w_sig_done   = 1'b1;
          end
        end else begin
          w_en            = 1'b1;
          w_sig_motor     = motor_de(r_canal);
          w_sig_canal_act = r_canal;
        end
      end
      PAUSA: begin
        if (abort) begin
          w_sig_estado = IDLE;
          w_sig_canal  = CANAL_NINGUNO;
          w_sig_busy   = 1'b0;
        end else if (w_cero) begin
          w_sig_estado    = RUN;
          w_carga         = 1'b1;
          w_sig_motor     = motor_de(r_canal);
          w_sig_canal_act = r_canal;
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        w_sig_estado = IDLE;
        w_sig_canal  = CANAL_NINGUNO;
        w_sig_busy   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= IDLE;
      r_canal     <= CANAL_NINGUNO;
      r_dosis     <= '0;
      r_motor     <= 3'b000;
      r_canal_act <= CANAL_NINGUNO;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_estado    <= w_sig_estado;
      r_canal     <= w_sig_canal;
      r_dosis     <= w_sig_dosis;
      r_motor     <= w_sig_motor;
      r_canal_act <= w_sig_canal_act;
      r_busy      <= w_sig_busy;
      r_done      <= w_sig_done;
      r_error     <= w_sig_error;
    end
  end

  assign motor_R      = r_motor[0];
  assign motor_G      = r_motor[1];
  assign motor_B      = r_motor[2];
  assign canal_activo = r_canal_act;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_secuenciador_dosificacion.sv
// Directed bench for the dosing sequencer: a table of dose vectors with
// hand-computed trace summaries, plus abort, re-enter and async-reset sequences.
module tb_secuenciador_dosificacion;

  localparam int W = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] R = '0, G = '0, B = '0;
  logic       motor_R, motor_G, motor_B, busy, done, error;
  logic [1:0] canal_activo;

  int n_checks = 0;
  int n_pass   = 0;

  secuenciador_dosificacion #(
    .CICLOS_POR_UNIDAD (4),
    .CICLOS_PAUSA      (2),
    .ANCHO_CONT        (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter        (enter),
    .abort        (abort),
    .R            (R),
    .G            (G),
    .B            (B),
    .motor_R      (motor_R),
    .motor_G      (motor_G),
    .motor_B      (motor_B),
    .canal_activo (canal_activo),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r, g, b;
    int err, dn, bsy, on_r, on_g, on_b, f_r, f_g, f_b;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Sample index i is taken at the negedge following edge k+i (k = enter edge).
  task automatic run_vec(input int id, input vec_t v, input int reenter_at);
    int n_busy, n_r, n_g, n_b, n_done, n_err, d_idx, f_r, f_g, f_b, n_ovl, n_can, exp_can;
    n_busy = 0; n_r = 0; n_g = 0; n_b = 0; n_done = 0; n_err = 0; d_idx = -1;
    f_r = -1; f_g = -1; f_b = -1; n_ovl = 0; n_can = 0;
    @(negedge clk); R = v.r; G = v.g; B = v.b; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) n_busy++;
      if (motor_R) begin n_r++; if (f_r < 0) f_r = i; end
      if (motor_G) begin n_g++; if (f_g < 0) f_g = i; end
      if (motor_B) begin n_b++; if (f_b < 0) f_b = i; end
      if (done) begin n_done++; if (d_idx < 0) d_idx = i; end
      if (error) n_err++;
      if (int'(motor_R) + int'(motor_G) + int'(motor_B) > 1) n_ovl++;
      exp_can = motor_R ? 1 : motor_G ? 2 : motor_B ? 3 : 0;
      if (int'(canal_activo) != exp_can) n_can++;
      if (i == reenter_at) begin R = 5'd15; enter = 1'b1; end
      else if (i == reenter_at + 1) enter = 1'b0;
    end
    chk($sformatf("v%0d error", id), n_err, v.err);
    chk($sformatf("v%0d done", id), n_done, v.dn);
    if (v.dn == 1) chk($sformatf("v%0d done_idx", id), d_idx, v.bsy);
    chk($sformatf("v%0d busy", id), n_busy, v.bsy);
    chk($sformatf("v%0d on_R", id), n_r, v.on_r);
    chk($sformatf("v%0d on_G", id), n_g, v.on_g);
    chk($sformatf("v%0d on_B", id), n_b, v.on_b);
    chk($sformatf("v%0d first_R", id), f_r, v.f_r);
    chk($sformatf("v%0d first_G", id), f_g, v.f_g);
    chk($sformatf("v%0d first_B", id), f_b, v.f_b);
    chk($sformatf("v%0d overlap", id), n_ovl, 0);
    chk($sformatf("v%0d canal", id), n_can, 0);
  endtask

  initial begin
    int n_act;
    //          r   g   b  err dn bsy  onR onG onB fR  fG  fB
    vecs[0] = '{5'd3, 5'd0, 5'd1, 0, 1, 18, 12, 0, 4, 0, -1, 14};
    vecs[1] = '{5'd2, 5'd2, 5'd16, 1, 0, 0, 0, 0, 0, -1, -1, -1};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, -1, -1, -1};
    vecs[3] = '{5'd1, 5'd1, 5'd1, 0, 1, 16, 4, 4, 4, 0, 6, 12};
    vecs[4] = '{5'd0, 5'd2, 5'd0, 0, 1, 8, 0, 8, 0, -1, 0, -1};
    vecs[5] = '{5'd15, 5'd0, 5'd0, 0, 1, 60, 60, 0, 0, 0, -1, -1};
    vecs[6] = '{5'd31, 5'd0, 5'd1, 1, 0, 0, 0, 0, 0, -1, -1, -1};
    vecs[7] = '{5'd1, 5'd0, 5'd2, 0, 1, 14, 4, 0, 8, 0, -1, 6};

    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset motors", int'({motor_R, motor_G, motor_B}), 0);
    chk("reset done/error", int'({done, error}), 0);
    chk("reset canal", int'(canal_activo), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i], -1);

    // Enter while busy (R forced to 15) must not disturb the latched run.
    run_vec(8, vecs[3], 3);
    R = 5'd0;

    // Abort and enter together in IDLE: nothing starts.
    @(negedge clk); R = 5'd1; G = 5'd1; B = 5'd1; enter = 1'b1; abort = 1'b1;
    @(negedge clk); enter = 1'b0; abort = 1'b0;
    n_act = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (busy || done || error || motor_R || motor_G || motor_B) n_act++;
    end
    chk("idle abort+enter", n_act, 0);

    // Abort during the 7th motor_R cycle of a 5/5/5 run.
    @(negedge clk); R = 5'd5; G = 5'd5; B = 5'd5; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    n_act = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (motor_R) n_act++;
    end
    chk("abort R cycles before", n_act, 7);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort motors", int'({motor_R, motor_G, motor_B}), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    n_act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || motor_R || motor_G || motor_B) n_act++;
    end
    chk("abort quiet", n_act, 0);
    begin
      vec_t v555;
      v555 = '{5'd5, 5'd5, 5'd5, 0, 1, 64, 20, 20, 20, 0, 22, 44};
      run_vec(9, v555, -1);
    end

    // Async reset between edges during the G run.
    @(negedge clk); R = 5'd1; G = 5'd1; B = 5'd1; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset motor_G", int'(motor_G), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst motors", int'({motor_R, motor_G, motor_B}), 0);
    chk("async rst busy/done/err", int'({busy, done, error}), 0);
    chk("async rst canal", int'(canal_activo), 0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(10, vecs[0], -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/secuenciador_dosificacion.md
Name: secuenciador_dosificacion

Overview:
Sequencer that drives the three colour-dosing motors (R, G, B) one at a time, never concurrently, so they can share one motor supply. On a start request it latches the three 0..15 dose values and runs each motor for dose × CICLOS_POR_UNIDAD cycles, in R → G → B order. Consecutive motors are separated by a fixed all-off pause. It sits between the dose-entry logic, which supplies R/G/B and the enter pulse, and the motor drivers.

Parameters:
CICLOS_POR_UNIDAD, 33_333, motor-on cycles per dose unit (15 units ≈ 500_000 cycles)
CICLOS_PAUSA, 1_000, all-motors-off cycles between consecutive motor runs (must be ≥ 1)
ANCHO_CONT, 32, counter width; 15 × CICLOS_POR_UNIDAD and CICLOS_PAUSA must each fit in ANCHO_CONT bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enter  input  1  start request, sampled on rising clk edge
abort  input  1  stop request, sampled on rising clk edge
R  input  5  red dose, 0..15 valid; 16 = not yet loaded
G  input  5  green dose, same encoding
B  input  5  blue dose, same encoding
motor_R  output  1  red motor enable
motor_G  output  1  green motor enable
motor_B  output  1  blue motor enable
canal_activo  output  2  0 = none, 1 = R, 2 = G, 3 = B (motor currently on)
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a sequence completes normally
error  output  1  one-cycle pulse when enter is rejected for an invalid dose

Behaviour:
- Reset (async, rst_n = 0): all outputs 0, FSM in IDLE, counter 0. Takes effect immediately, including mid-run; motors drop without waiting for clk.
- All outputs are registered. At most one motor_* is high in any cycle.
- FSM states: IDLE, RUN, PAUSA. A channel index (R, G, B) is kept alongside the state.
- IDLE, enter = 1 at edge k, abort = 0:
  - If any of R/G/B > 15: error = 1 for one cycle; no other change.
  - Else latch R/G/B.
  - If all three are zero: done = 1 for one cycle; busy stays 0.
  - Otherwise, after edge k: busy = 1, state RUN on the first non-zero channel, its motor high, counter loaded with N−1, where N = dose × CICLOS_POR_UNIDAD.
- RUN: the motor stays high for exactly N cycles, i.e. after edges k..k+N−1. At the edge where the counter is 0:
  - If a later non-zero channel exists: motor low, state PAUSA, counter = CICLOS_PAUSA−1.
  - Else: motor low, busy = 0, done = 1 (same edge), state IDLE.
- Zero-dose channels are skipped entirely: no run and no extra pause. Exactly one pause separates each pair of consecutive non-zero runs.
- PAUSA: all motors off for exactly CICLOS_PAUSA cycles. Then RUN on the next non-zero channel with its counter loaded.
- canal_activo follows the active motor; it is 0 in IDLE and PAUSA.
- Latched doses are used for the whole sequence. Changes on R/G/B during busy have no effect.
- enter while busy is ignored; no error is raised.
- abort = 1 while busy, in any state: at that edge all motors go low, busy = 0, state IDLE, no done pulse.
- abort = 1 in IDLE takes priority over a simultaneous enter: nothing happens.
- Arithmetic: the dose is zero-extended to ANCHO_CONT, and dose × CICLOS_POR_UNIDAD is a constant-multiplier product. The counter counts down, with a zero-detect flag.

Decomposition:
- Shared package: FSM state encoding, canal_activo codes, VALOR_MAX = 15, VALOR_NO_CARGADO = 16.
- One sub-module: contador_descendente. Loadable ANCHO_CONT-bit down-counter with load, enable and zero flag, with the same clk/rst_n reset style. It is reused for both run and pause timing.

Test Plan:
All scenarios use CICLOS_POR_UNIDAD = 4 and CICLOS_PAUSA = 2.
- R=3, G=0, B=1, enter pulse → motor_R high 12 cycles, 2 cycles all off, motor_B high 4 cycles; motor_G never high; done pulses on the edge motor_B falls; busy high for 18 cycles.
- R=2, G=2, B=16, enter → error pulses 1 cycle; busy, done and all motors stay 0.
- R=G=B=0, enter → done pulses 1 cycle after the enter edge; busy and motors never high.
- R=5, G=5, B=5, enter, abort on the 7th motor_R cycle → all motors 0 at the next edge, busy = 0, no done; a new enter then runs a full sequence normally.
- R=1, G=1, B=1, enter; during the run set R=15 and pulse enter again → ignored; total busy = 16 cycles (4+2+4+2+4).
- Mid motor_G run, drive rst_n = 0 between clock edges → all outputs 0 immediately; after release the block is in IDLE and accepts enter.
